jk_bank_sequencer: RTL and testbench

//  Command-driven controller for a bank of WIDTH JK flip-flops held inside the block.
//  It accepts LOAD/CLEAR/SET/TOGGLE/COUNT commands over a valid/ready handshake.
//  For each command it derives the per-bit J/K drive and sequences single- or multi-cycle execution.
//  It sits between a host/control FSM and any logic that consumes the bank state q.

---
 rtl/jk_bank_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// jk_bank_sequencer
//   Command-driven controller for an internal bank of WIDTH JK flip-flops.
//   Commands are accepted over a valid/ready handshake. The block derives the
//   per-bit J/K drive for each command and runs it in one of two ways:
//     - single-cycle execution (EXEC) for LOAD/CLEAR/TOGGLE/SET/NOP/reserved
//     - multi-cycle binary counting (RUN) for CNT_UP/CNT_DN
//
// Ports
//   clk        in   1       clock; all state updates on the rising edge
//   rst        in   1       asynchronous, active-high reset
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       command can be accepted (high only in IDLE)
//   cmd_op     in   3       0 NOP, 1 LOAD, 2 CLEAR, 3 TOGGLE, 4 CNT_UP,
//                           5 CNT_DN, 6 SET, 7 reserved
//   cmd_arg    in   WIDTH   value (LOAD) or bit mask (TOGGLE/SET)
//   cmd_steps  in   STEP_W  number of count steps (CNT_UP/CNT_DN)
//   abort      in   1       stops a running count; sampled only in RUN
//   j_vec      out  WIDTH   J drive applied to the bank this cycle
//   k_vec      out  WIDTH   K drive applied to the bank this cycle
//   q          out  WIDTH   bank state
//   busy       out  1       high in EXEC or RUN
//   done       out  1       one-cycle pulse when a command completes
//   wrap       out  1       one-cycle pulse when a count step wraps around
//   err        out  1       one-cycle pulse when the reserved op completes
// -----------------------------------------------------------------------------
module jk_bank_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_arg,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic [WIDTH-1:0]  j_vec,
    output logic [WIDTH-1:0]  k_vec,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_CLEAR  = 3'd2,
        OP_TOGGLE = 3'd3,
        OP_CNT_UP = 3'd4,
        OP_CNT_DN = 3'd5,
        OP_SET    = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    state_t              r_state;
    state_t              w_state_nxt;

    op_e                 r_op;
    logic [WIDTH-1:0]    r_arg;
    logic [STEP_W-1:0]   r_cnt;
    logic [WIDTH-1:0]    r_q;
    logic                r_done;
    logic                r_wrap;
    logic                r_err;

    logic                w_accept;
    logic                w_is_count;
    logic [STEP_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]    w_j;
    logic [WIDTH-1:0]    w_k;
    logic [WIDTH-1:0]    w_up_tgl;
    logic [WIDTH-1:0]    w_dn_tgl;
    logic                w_done_nxt;
    logic                w_wrap_nxt;
    logic                w_err_nxt;

    // Ripple toggle masks for a binary step: bit i flips when every lower bit
    // is 1 (counting up) or 0 (counting down); bit 0 always flips.
    always_comb begin
        logic up_carry;
        logic dn_borrow;
        up_carry  = 1'b1;
        dn_borrow = 1'b1;
        w_up_tgl  = '0;
        w_dn_tgl  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_tgl[i] = up_carry;
            w_dn_tgl[i] = dn_borrow;
            up_carry    = up_carry & r_q[i];
            dn_borrow   = dn_borrow & ~r_q[i];
        end
    end

    assign w_is_count = (op_e'(cmd_op) == OP_CNT_UP) || (op_e'(cmd_op) == OP_CNT_DN);

    // Next-state, J/K drive and next values of the registered pulses.
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_j         = '0;
        w_k         = '0;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (w_is_count && (cmd_steps != '0)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = cmd_steps;
                    end else begin
                        // Zero-step counts fall through here and run as a
                        // no-drive EXEC cycle.
                        w_state_nxt = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                case (r_op)
                    OP_LOAD: begin
                        w_j = r_arg;
                        w_k = ~r_arg;
                    end
                    OP_CLEAR: begin
                        w_k = '1;
                    end
                    OP_TOGGLE: begin
                        w_j = r_arg;
                        w_k = r_arg;
                    end
                    OP_SET: begin
                        w_j = r_arg;
                    end
                    default: begin
                        // NOP, reserved and zero-step counts hold the bank.
                    end
                endcase
                w_done_nxt  = 1'b1;
                w_err_nxt   = (r_op == OP_RSVD);
                w_state_nxt = ST_IDLE;
            end

            ST_RUN: begin
                if (abort) begin
                    // Abort wins over the step, including the final one.
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (r_op == OP_CNT_UP) begin
                        w_j        = w_up_tgl;
                        w_k        = w_up_tgl;
                        w_wrap_nxt = &r_q;
                    end else begin
                        w_j        = w_dn_tgl;
                        w_k        = w_dn_tgl;
                        w_wrap_nxt = ~|r_q;
                    end
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == STEP_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_NOP;
            r_arg  <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(cmd_op);
                r_arg <= cmd_arg;
            end
            r_cnt  <= w_cnt_nxt;
            // JK rule per bit: 00 hold, 01 clear, 10 set, 11 toggle.
            r_q    <= (w_j & ~r_q) | (~w_k & r_q);
            r_done <= w_done_nxt;
            r_wrap <= w_wrap_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign j_vec     = w_j;
    assign k_vec     = w_k;
    assign q         = r_q;
    assign done      = r_done;
    assign wrap      = r_wrap;
    assign err       = r_err;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_sequencer
//   Scoreboard bench for jk_bank_sequencer (WIDTH=4, STEP_W=8). Each command
//   pushes its expected completion (final q, acceptance-to-done latency, wrap
//   pulses seen, err) when it is driven; a monitor pops and compares on done.
//   Directed checks cover J/K drive, intermediate count values and reset.
// -----------------------------------------------------------------------------
module tb_jk_bank_sequencer;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_CLEAR  = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_CNT_UP = 3'd4;
    localparam logic [2:0] OP_CNT_DN = 3'd5;
    localparam logic [2:0] OP_SET    = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_arg;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;
    logic [WIDTH-1:0]  j_vec;
    logic [WIDTH-1:0]  k_vec;
    logic [WIDTH-1:0]  q;
    logic              busy;
    logic              done;
    logic              wrap;
    logic              err;

    typedef struct {
        logic [WIDTH-1:0] q;
        int               lat;
        int               wraps;
        logic             err;
        int               acc;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wraps_seen  = 0;

    jk_bank_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .j_vec     (j_vec),
        .k_vec     (k_vec),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drives a command, holding cmd_valid until the DUT is ready, and records
    // the expected completion. Returns just after the acceptance edge.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] arg,
                        input logic [STEP_W-1:0] steps, input logic [WIDTH-1:0] eq,
                        input int lat, input int wr, input logic eerr);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_steps = steps;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", {31'b0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.q     = eq;
        e.lat   = lat;
        e.wraps = wr;
        e.err   = eerr;
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                wraps_seen = 0;
            end else begin
                if (wrap) wraps_seen++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", {31'b0, done}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("done_q", {28'b0, q}, {28'b0, e.q});
                        check("done_latency", cyc - e.acc, e.lat);
                        check("done_wraps", wraps_seen, e.wraps);
                        check("done_err", {31'b0, err}, {31'b0, e.err});
                    end
                    wraps_seen = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] up_seq [3];
        logic             up_wr  [3];
        logic [WIDTH-1:0] dn_seq [2];
        logic             dn_wr  [2];
        bit               idle_ok;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = '0;
        cmd_steps = '0;
        abort     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_q", {28'b0, q}, 32'h0);
        check("rst_j", {28'b0, j_vec}, 32'h0);
        check("rst_k", {28'b0, k_vec}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_wrap_err", {30'b0, wrap, err}, 32'd0);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        rst = 1'b0;

        // T1: LOAD 0xA
        send(OP_LOAD, 4'hA, 8'd0, 4'hA, 1, 0, 1'b0);
        check("load_j", {28'b0, j_vec}, 32'hA);
        check("load_k", {28'b0, k_vec}, 32'h5);
        check("load_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        check("load_q", {28'b0, q}, 32'hA);
        check("load_done", {31'b0, done}, 32'd1);
        check("load_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        check("load_done_1cyc", {31'b0, done}, 32'd0);

        // T2: TOGGLE, SET, CLEAR
        send(OP_TOGGLE, 4'h3, 8'd0, 4'h9, 1, 0, 1'b0);
        check("toggle_jk", {24'b0, j_vec, k_vec}, 32'h33);
        send(OP_SET, 4'h4, 8'd0, 4'hD, 1, 0, 1'b0);
        check("set_jk", {24'b0, j_vec, k_vec}, 32'h40);
        send(OP_CLEAR, 4'h0, 8'd0, 4'h0, 1, 0, 1'b0);
        check("clear_jk", {24'b0, j_vec, k_vec}, 32'h0F);

        // T3: CNT_UP by 3 from 0xE, wrapping on F->0
        send(OP_LOAD, 4'hE, 8'd0, 4'hE, 1, 0, 1'b0);
        send(OP_CNT_UP, 4'h0, 8'd3, 4'h1, 3, 1, 1'b0);
        check("up_j_from_e", {28'b0, j_vec}, 32'h1);
        up_seq = '{4'hF, 4'h0, 4'h1};
        up_wr  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("up_step_q", {28'b0, q}, {28'b0, up_seq[i]});
            check("up_step_wrap", {31'b0, wrap}, {31'b0, up_wr[i]});
        end

        // T4: CNT_DN by 2 from 0, then a zero-step count
        send(OP_LOAD, 4'h0, 8'd0, 4'h0, 1, 0, 1'b0);
        send(OP_CNT_DN, 4'h0, 8'd2, 4'hE, 2, 1, 1'b0);
        check("dn_j_from_0", {28'b0, j_vec}, 32'hF);
        dn_seq = '{4'hF, 4'hE};
        dn_wr  = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("dn_step_q", {28'b0, q}, {28'b0, dn_seq[i]});
            check("dn_step_wrap", {31'b0, wrap}, {31'b0, dn_wr[i]});
        end
        send(OP_CNT_UP, 4'h0, 8'd0, 4'hE, 1, 0, 1'b0);
        check("zero_step_jk", {24'b0, j_vec, k_vec}, 32'h00);
        check("zero_step_busy", {31'b0, busy}, 32'd1);

        // T5: abort in the 4th RUN cycle while a LOAD is held off
        send(OP_LOAD, 4'h0, 8'd0, 4'h0, 1, 0, 1'b0);
        send(OP_CNT_UP, 4'h0, 8'd10, 4'h3, 4, 0, 1'b0);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("held_ready_low", {31'b0, cmd_ready}, 32'd0);
                end
                check("pre_abort_q", {28'b0, q}, 32'h3);
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check("abort_q", {28'b0, q}, 32'h3);
                check("abort_done", {31'b0, done}, 32'd1);
                check("abort_busy", {31'b0, busy}, 32'd0);
            end
            begin
                send(OP_LOAD, 4'h5, 8'd0, 4'h5, 1, 0, 1'b0);
            end
        join

        // T6: reserved op, then reset mid-RUN
        send(OP_RSVD, 4'hF, 8'd0, 4'h5, 1, 0, 1'b1);
        @(posedge clk); #1;
        check("rsvd_err_done", {30'b0, err, done}, 32'h3);
        check("rsvd_q", {28'b0, q}, 32'h5);

        send(OP_CNT_UP, 4'h0, 8'd5, 4'h0, 0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_run_q", {28'b0, q}, 32'h7);
        rst = 1'b1;
        #1;
        check("rst_mid_q", {28'b0, q}, 32'h0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_q", {28'b0, q}, 32'h0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);

        // Drain: nothing should remain outstanding
        idle_ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready && sb.size() == 0) begin
                idle_ok = 1'b1;
                break;
            end
        end
        check("sb_drained", sb.size(), 32'd0);
        if (!idle_ok) check("drain_ready", {31'b0, cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
